// File: rtl/fft64_reorder_buf_pkg.sv
// fft64_reorder_buf shared constants and types.
// Frame geometry, default sample width and read-path latency.
package fft64_reorder_buf_pkg;

  localparam int USFFT64paramnb = 16;
  localparam int FFT_LEN = 64;
  localparam int AW = 6;
  localparam int READ_LAT = 3;

  localparam logic [AW-1:0] LAST = AW'(FFT_LEN - 1);

  typedef enum logic {
    IDLE,
    RUN
  } wstate_t;

endpackage

// File: rtl/fft64_reorder_buf_ram64.sv
// fft64_reorder_buf single-port 64-word RAM bank.
// Read data appears two enabled cycles after the address.
module fft64_reorder_buf_ram64
  import fft64_reorder_buf_pkg::*;
#(
  parameter int W = USFFT64paramnb
) (
  input  logic          CLK,
  input  logic          ED,
  input  logic          WE,
  input  logic [AW-1:0] ADDR,
  input  logic [W-1:0]  D,
  output logic [W-1:0]  Q
);

  logic [W-1:0] mem [FFT_LEN];
  logic [W-1:0] q1;

  // write port plus two-stage registered read
  always_ff @(posedge CLK) begin
    if (ED) begin
      if (WE) mem[ADDR] <= D;
      q1 <= mem[ADDR];
      Q  <= q1;
    end
  end

endmodule

// File: rtl/fft64_reorder_buf.sv
// fft64_reorder_buf: ping-pong natural-in, permuted-out frame buffer.
// One bank fills while the other is read in bit-reverse or transpose order.
module fft64_reorder_buf
  import fft64_reorder_buf_pkg::*;
#(
  parameter int nb = USFFT64paramnb,
  parameter int ORDER = 0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ED,
  input  logic          START,
  input  logic [nb-1:0] DR,
  input  logic [nb-1:0] DI,
  output logic          RDY,
  output logic [nb-1:0] DOR,
  output logic [nb-1:0] DOI
);

  function automatic logic [AW-1:0] perm(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    if (ORDER == 0) begin
      for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    end else begin
      r = {a[2:0], a[5:3]};
    end
    return r;
  endfunction

  wstate_t       st, st_n;
  logic [AW-1:0] wcnt, wcnt_n;
  logic          wbank, wbank_n;
  logic          arm;
  logic          wen;
  logic [AW-1:0] waddr;

  logic          rd_act;
  logic [AW-1:0] rcnt;
  logic [AW-1:0] raddr;

  logic [READ_LAT-2:0] vd, fd, sd;

  logic [AW-1:0] baddr [2];
  logic          bwe   [2];
  logic [nb-1:0] qr    [2];
  logic [nb-1:0] qi    [2];

  // write FSM next state, write address and frame-complete arming
  always_comb begin
    st_n    = st;
    wcnt_n  = wcnt;
    wbank_n = wbank;
    arm     = 1'b0;
    wen     = 1'b0;
    waddr   = wcnt;
    unique case (st)
      IDLE: begin
        if (START) begin
          st_n   = RUN;
          wen    = 1'b1;
          waddr  = '0;
          wcnt_n = AW'(1);
        end
      end
      RUN: begin
        wen = 1'b1;
        if (START) begin
          waddr  = '0;
          wcnt_n = AW'(1);
        end else begin
          wcnt_n = wcnt + AW'(1);
          if (wcnt == LAST) begin
            wbank_n = ~wbank;
            arm     = 1'b1;
          end
        end
      end
    endcase
  end

  // write FSM state, counter and bank registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st    <= IDLE;
      wcnt  <= '0;
      wbank <= 1'b0;
    end else if (ED) begin
      st    <= st_n;
      wcnt  <= wcnt_n;
      wbank <= wbank_n;
    end
  end

  // read counter: 64 cycles per arming, seamless when re-armed at wrap
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_act <= 1'b0;
      rcnt   <= '0;
    end else if (ED) begin
      if (arm) begin
        rd_act <= 1'b1;
        rcnt   <= '0;
      end else if (rd_act) begin
        rcnt <= rcnt + AW'(1);
        if (rcnt == LAST) rd_act <= 1'b0;
      end
    end
  end

  assign raddr = perm(rcnt);

  // bank port ownership: writer gets wcnt/WE, the other bank is read
  always_comb begin
    baddr[0] = wbank ? raddr : waddr;
    bwe[0]   = ~wbank & wen;
    baddr[1] = wbank ? waddr : raddr;
    bwe[1]   = wbank & wen;
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    fft64_reorder_buf_ram64 #(.W(nb)) u_re (
      .CLK  (CLK),
      .ED   (ED),
      .WE   (bwe[g]),
      .ADDR (baddr[g]),
      .D    (DR),
      .Q    (qr[g])
    );
    fft64_reorder_buf_ram64 #(.W(nb)) u_im (
      .CLK  (CLK),
      .ED   (ED),
      .WE   (bwe[g]),
      .ADDR (baddr[g]),
      .D    (DI),
      .Q    (qi[g])
    );
  end

  // valid, first-sample and bank-select delayed to match RAM latency
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vd <= '0;
      fd <= '0;
      sd <= '0;
    end else if (ED) begin
      vd <= {vd[READ_LAT-3:0], rd_act};
      fd <= {fd[READ_LAT-3:0], rd_act && (rcnt == '0)};
      sd <= {sd[READ_LAT-3:0], ~wbank};
    end
  end

  // output register: capture read data, pulse RDY on sample 0
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RDY <= 1'b0;
      DOR <= '0;
      DOI <= '0;
    end else if (ED) begin
      RDY <= vd[READ_LAT-2] & fd[READ_LAT-2];
      if (vd[READ_LAT-2]) begin
        DOR <= qr[sd[READ_LAT-2]];
        DOI <= qi[sd[READ_LAT-2]];
      end
    end
  end

endmodule
